// File: rtl/adder_pkg.sv
// Shared sizing helper and token control bits for the pipelined adder family.
// Data buses stay outside the struct so WIDTH can remain a module parameter.
package adder_pkg;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic vld;
        logic carry;
    } tok_ctl_t;

endpackage

// File: rtl/adder_pipe_slice.sv
// One SLICE-bit carry-chained add stage with its token register and advance logic.
// Latency: 1 cycle. Backpressure: holds its token while dn_rdy is low; ready when empty or advancing.
// With ADDER_PIPE_OVF_EN defined, also registers the signed-overflow flag for the sum so far.
module adder_pipe_slice
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  tok_ctl_t         up_ctl,
    input  logic [WIDTH-1:0] up_sum,
    input  logic [WIDTH-1:0] up_x,
    input  logic [WIDTH-1:0] up_y,
    output logic             up_rdy,
    output tok_ctl_t         dn_ctl,
    output logic [WIDTH-1:0] dn_sum,
    output logic [WIDTH-1:0] dn_x,
    output logic [WIDTH-1:0] dn_y,
    input  logic             dn_rdy
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             dn_ovf
`endif
);

    localparam int SLICE = slice_w(WIDTH, STAGES);
    localparam int LO    = IDX * SLICE;

    tok_ctl_t         ctl_q, ctl_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SLICE:0]   part;
    logic             adv;
    logic             load;

    always_comb begin
        part   = {1'b0, up_x[LO +: SLICE]} + {1'b0, up_y[LO +: SLICE]}
               + {{SLICE{1'b0}}, up_ctl.carry};
        adv    = ctl_q.vld && dn_rdy;
        up_rdy = !ctl_q.vld || adv;
        load   = up_ctl.vld && up_rdy;

        ctl_d = ctl_q;
        sum_d = sum_q;
        x_d   = x_q;
        y_d   = y_q;
        // Valid follows upstream whenever this stage frees up, so bubbles collapse.
        if (up_rdy) begin
            ctl_d.vld = up_ctl.vld;
        end
        if (load) begin
            ctl_d.carry       = part[SLICE];
            sum_d             = up_sum;
            sum_d[LO +: SLICE] = part[SLICE-1:0];
            x_d               = up_x;
            y_d               = up_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '0;
            sum_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            ctl_q <= ctl_d;
            sum_q <= sum_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign dn_ctl = ctl_q;
    assign dn_sum = sum_q;
    assign dn_x   = x_q;
    assign dn_y   = y_q;

`ifdef ADDER_PIPE_OVF_EN
    logic ovf_q, ovf_d;

    // Only meaningful in the last stage, where sum_d holds the complete sum.
    always_comb begin
        ovf_d = ovf_q;
        if (load) begin
            ovf_d = (up_x[WIDTH-1] == up_y[WIDTH-1]) && (sum_d[WIDTH-1] != up_x[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign dn_ovf = ovf_q;
`endif

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit ripple-carry adder (x + y + cin) split into STAGES carry-chained slices; ovf port via ADDER_PIPE_OVF_EN.
// Latency: STAGES register stages (result valid STAGES-1 edges after the accepting edge); 1 add/cycle.
// Backpressure: full valid/ready; outputs held stable while out_valid && !out_ready, in_ready drops when full.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    generate
        if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
        end
    endgenerate

    // Index k is the input of slice k; index STAGES is the pipeline output.
    tok_ctl_t         ctl_s [STAGES+1];
    logic [WIDTH-1:0] sum_s [STAGES+1];
    logic [WIDTH-1:0] x_s   [STAGES+1];
    logic [WIDTH-1:0] y_s   [STAGES+1];
    logic             rdy_s [STAGES+1];
`ifdef ADDER_PIPE_OVF_EN
    logic             ovf_s [STAGES];
`endif

    assign ctl_s[0].vld   = in_valid;
    assign ctl_s[0].carry = cin;
    assign sum_s[0]       = '0;
    assign x_s[0]         = x;
    assign y_s[0]         = y;
    assign rdy_s[STAGES]  = out_ready;
    assign in_ready       = rdy_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_slice #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .up_ctl (ctl_s[k]),
            .up_sum (sum_s[k]),
            .up_x   (x_s[k]),
            .up_y   (y_s[k]),
            .up_rdy (rdy_s[k]),
            .dn_ctl (ctl_s[k+1]),
            .dn_sum (sum_s[k+1]),
            .dn_x   (x_s[k+1]),
            .dn_y   (y_s[k+1]),
            .dn_rdy (rdy_s[k+1])
`ifdef ADDER_PIPE_OVF_EN
            ,
            .dn_ovf (ovf_s[k])
`endif
        );
    end

    assign out_valid = ctl_s[STAGES].vld;
    assign sum       = sum_s[STAGES];
    assign cout      = ctl_s[STAGES].carry;
`ifdef ADDER_PIPE_OVF_EN
    assign ovf       = ovf_s[STAGES-1];
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (WIDTH=16, STAGES=4): vector table plus handshake corner sequences and random traffic.
module tb_adder_pipe;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
`ifdef ADDER_PIPE_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   n_deliv = 0;
    int   acc_cyc = 0;
    int   deliv_cyc[$];
    exp_t sbq[$];
    exp_t mon_e;
    bit   saw_stall = 1'b0;
    logic hold_pend = 1'b0;
    logic [W-1:0] held_sum = '0;
    logic held_co = 1'b0;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Consumer: 0 always ready, 1 toggling, 2 random, otherwise stalled.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Output monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("hold_stable", {out_valid, cout, sum}, {1'b1, held_co, held_sum});
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                n_deliv++;
                deliv_cyc.push_back(cyc);
                if (sbq.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sum", sum, mon_e.s);
                    chk("cout", cout, mon_e.co);
`ifdef ADDER_PIPE_OVF_EN
                    chk("ovf", ovf, mon_e.ov);
`endif
                end
            end
            hold_pend = out_valid && !out_ready;
            held_sum  = sum;
            held_co   = cout;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic eco);
        exp_t e;
        bit   accepted;
        int   n;
        e.s  = es;
        e.co = eco;
        e.ov = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
        x = a; y = b; cin = c; in_valid = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(e);
                acc_cyc  = cyc;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL accept_timeout actual=not_accepted expected=accepted x=%h", a);
        end
    endtask

    task automatic send_rand(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        r = model(a, b, c);
        send(a, b, c, r[W-1:0], r[W]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        wait_cycles(1);
        chk("drain_left", sbq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vec[11];
        int   n0;
        int   span;

        vec[0]  = '{16'h1111, 16'h4444, 1'b0, 16'h5555, 1'b0};
        vec[1]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vec[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vec[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vec[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vec[5]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vec[6]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vec[7]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vec[8]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vec[9]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vec[10] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        wait_cycles(1);

        // Isolated vectors: value and latency of each
        rdy_mode = 0;
        for (int i = 0; i < 11; i++) begin
            deliv_cyc.delete();
            send(vec[i].x, vec[i].y, vec[i].cin, vec[i].s, vec[i].co);
            in_valid = 1'b0;
            drain();
            chk("latency", (deliv_cyc.size() == 1) ? deliv_cyc[0] - acc_cyc : -1, S);
        end

        // Eight back-to-back tokens with a free-running consumer
        deliv_cyc.delete();
        for (int i = 0; i < 8; i++) send_rand(W'(i), W'(16'h0F0F * i), 1'b0);
        in_valid = 1'b0;
        drain();
        span = (deliv_cyc.size() == 8) ? deliv_cyc[7] - deliv_cyc[0] : -1;
        chk("b2b_count", deliv_cyc.size(), 8);
        chk("b2b_span", span, 7);

        // Same tokens with a toggling consumer
        rdy_mode  = 1;
        saw_stall = 1'b0;
        deliv_cyc.delete();
        for (int i = 0; i < 8; i++) send_rand(W'(i), W'(16'h0F0F * i), 1'b0);
        in_valid = 1'b0;
        drain();
        chk("toggle_count", deliv_cyc.size(), 8);
        chk("toggle_stall_seen", saw_stall, 1);

        // Reset with tokens in flight
        rdy_mode = 3;
        wait_cycles(2);
        for (int i = 0; i < 3; i++) send_rand(W'(16'h0101 * (i + 1)), 16'h1111, 1'b1);
        in_valid = 1'b0;
        wait_cycles(5);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        n0       = n_deliv;
        wait_cycles(10);
        chk("no_stale_after_rst", n_deliv - n0, 0);

`ifdef ADDER_PIPE_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        in_valid = 1'b0;
        drain();
`endif

        // Random traffic with random gaps and consumer stalls
        rdy_mode = 2;
        n0 = n_deliv;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                wait_cycles(1);
            end
            send_rand(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();
        chk("rand_count", n_deliv - n0, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
